// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request in, valid/ready response out,
// programmable wait states, byte-lane RAM. Optional misalignment check via DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
`ifdef DMEM_MISALIGN_CHK_EN
    output logic        rsp_err,
`endif
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [7:0] WAIT_LOAD = 8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg;
    logic [7:0]      cnt_reg;
    logic            we_reg;
    logic [AW-1:0]   idx_reg;
    logic [31:0]     wdata_reg;
    logic [3:0]      be_reg;
    logic            rdata_sel_reg;
    logic [31:0]     rd_word;

    logic            op_we;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_wdata;
    logic [3:0]      op_be;
    logic            op_mis;
    logic            entry;
    logic            mem_wr;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    // With zero wait states the RAM is touched on the accept edge itself, so use the live request.
    assign op_we    = (state_reg == IDLE) ? req_we            : we_reg;
    assign op_idx   = (state_reg == IDLE) ? req_addr[AW+1:2]  : idx_reg;
    assign op_wdata = (state_reg == IDLE) ? req_wdata         : wdata_reg;
    assign op_be    = (state_reg == IDLE) ? req_be            : be_reg;

`ifdef DMEM_MISALIGN_CHK_EN
    logic [1:0] off_reg;
    logic       err_reg;
    assign op_mis  = ((state_reg == IDLE) ? req_addr[1:0] : off_reg) != 2'b00;
    assign rsp_err = err_reg;
`else
    assign op_mis  = 1'b0;
`endif

    assign entry  = ((state_reg == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                    ((state_reg == WAIT) && (cnt_reg == 8'd0));
    assign mem_wr = entry && op_we && !op_mis && reset;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] bank [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (mem_wr && op_be[gi]) begin
                    bank[op_idx] <= op_wdata[gi*8 +: 8];
                end
                if (entry && reset) begin
                    rd_byte_reg <= bank[op_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    // Stores and faulted accesses return zero; loads return the word captured on the entry edge.
    assign rsp_rdata = rdata_sel_reg ? rd_word : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 8'd0;
            we_reg        <= 1'b0;
            idx_reg       <= '0;
            wdata_reg     <= 32'd0;
            be_reg        <= 4'd0;
            rdata_sel_reg <= 1'b0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            busy          <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
            off_reg       <= 2'b00;
            err_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        idx_reg   <= req_addr[AW+1:2];
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
`ifdef DMEM_MISALIGN_CHK_EN
                        off_reg   <= req_addr[1:0];
`endif
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_reg <= WAIT;
                            cnt_reg   <= WAIT_LOAD;
                        end else begin
                            state_reg     <= RESP;
                            rdata_sel_reg <= !op_we && !op_mis;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 8'd0) begin
                        state_reg     <= RESP;
                        rdata_sel_reg <= !op_we && !op_mis;
                    end else begin
                        cnt_reg <= cnt_reg - 8'd1;
                    end
                end
                RESP: begin
                    // First RESP cycle is the registered RAM read; rsp_valid rises after it.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
`ifdef DMEM_MISALIGN_CHK_EN
                        err_reg   <= op_mis;
`endif
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
                        err_reg   <= 1'b0;
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
